banked_iomemory: RTL and testbench
==================================

# banked_iomemory

Parametrised memory-mapped I/O memory for the interpolation ASIP: a banked data RAM with scalar and multi-lane vector access from the processor, a byte-wide keyed read port for the display/GPU side, and a button-interrupt status register. Vector accesses are striped across NUM_BANKS banks and complete in LANES/NUM_BANKS beats, with a valid/ready stall handshake. It sits between the core's load/store unit and the display pipeline, in the core's clock domain.

## Interface
- DATA_WIDTH, 32, scalar word width (multiple of 8)
- ADDR_WIDTH, 32, byte-address width
- DEPTH, 1024, RAM size in words (multiple of LANES)
- LANES, 4, words per vector access
- NUM_BANKS, 2, RAM banks; must divide LANES
- STATUS_ADDR, 'h30000, status/interrupt register byte address
- KEY_ADDR, 'h30004, stream key register byte address
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  processor request present
- req_ready  out  1  block accepts a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_vector  in  1  1 = LANES-word vector access
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- wdata  in  LANES*DATA_WIDTH  write data; scalar uses bits [DATA_WIDTH-1:0], lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- rdata  out  LANES*DATA_WIDTH  read data, same lane layout; scalar zero-extended
- rvalid  out  1  one-cycle pulse, rdata valid (reads only)
- button_in  in  1  asynchronous start button
- irq  out  1  pending AND enable
- stream_addr  in  ADDR_WIDTH  display byte address, sampled every cycle
- stream_data  out  8  byte at stream_addr XOR key, one cycle later
- stream_valid  out  1  stream_data corresponds to an in-range address

## Operation
- Word index w = req_addr[ADDR_WIDTH-1:2]; word w lives in bank w % NUM_BANKS, row w / NUM_BANKS. Each bank: one processor port, one stream read port.
- Vector base = w rounded down to a multiple of LANES; lane i = word base+i. Beat b (0..BEATS-1, BEATS = LANES/NUM_BANKS) accesses lanes b*NUM_BANKS..b*NUM_BANKS+NUM_BANKS-1 in parallel.
- FSM: IDLE (req_ready=1) -> accepted vector with BEATS>1 -> BUSY (beat counter 1..BEATS-1, req_ready=0) -> IDLE after final beat. Scalar and BEATS=1 accesses stay in IDLE.
- Writes: commit at beat edge; no rvalid. Reads: rdata assembled across beats, held until next read result.
- STATUS (scalar only): bit0 pending (set on synchronised rising edge of button_in; read returns value and clears; write 1 clears), bit1 irq enable (R/W). Set and clear in same cycle: set wins.
- KEY (scalar only): bits [7:0] R/W, other bits read 0.
- Word address >= DEPTH other than STATUS/KEY, or any vector access to STATUS/KEY: write ignored, read returns 0 with normal rvalid timing.
- Stream: byte lane stream_addr[1:0], little endian. Out-of-range: stream_data=0, stream_valid=0. Same-edge processor write to the same word: stream returns old data.

## Timing
- Reset (rst_n low at an edge): FSM IDLE, beat counter 0, rvalid=0, rdata=0, stream_data=0, stream_valid=0, pending=0, enable=0, KEY=0, synchroniser flops 0, irq=0. req_ready=0 while rst_n is low. RAM contents not reset.
- Reset during BUSY: transfer aborted, no rvalid; beats already written stay written.
- Accept at edge T (req_valid & req_ready). Scalar read: rvalid in cycle after T; back-to-back scalar accesses every cycle.
- Vector: beat b at edge T+b; req_ready=0 in cycles T+1..T+BEATS-1; read rvalid in cycle after edge T+BEATS-1.
- Button: 2-flop synchroniser plus edge detector; high level first sampled at edge E sets pending at edge E+2; irq is a combinational AND of registered bits.
- Stream: address sampled at edge E, stream_data/stream_valid valid after E.

## Test plan
- Scalar write 'hA to 'h10, then scalar read 'h10 -> rvalid next cycle, rdata='hA, req_ready never drops.
- LANES=4, NUM_BANKS=2: vector write lanes {1,2,3,4} to 'h404 (base word 'h100) -> req_ready low exactly 1 cycle; vector read 'h400 -> rvalid 2 cycles after accept, rdata lanes {1,2,3,4}; scalar read 'h408 -> 3.
- Write KEY='h5A, word 'h10='h11223344; stream_addr 'h10..'h13 -> stream_data 'h1E,'h69,'h78,'h4B; stream_addr 'h30000 -> stream_valid=0, data 0.
- Set STATUS enable=1, pulse button_in -> irq high 2 edges after sampling; read STATUS -> rdata='h3, irq low next cycle; second read -> 'h2.
- Assert rst_n low mid-vector write at beat 1 -> no further beats, req_ready 0 during reset, 1 after; STATUS/KEY read 0.
- Read word DEPTH and vector read at STATUS_ADDR -> rdata 0, rvalid at normal latency; write there leaves all state unchanged.

Source files
------------

// File: rtl/banked_iomemory.sv
// banked_iomemory
//   Memory-mapped I/O memory for the interpolation ASIP. It holds a data RAM
//   striped across NUM_BANKS banks, a button-interrupt status register and an
//   8-bit stream key.
//   - The processor side supports scalar and LANES-word vector access with a
//     valid/ready stall. A vector access takes BEATS = LANES/NUM_BANKS beats,
//     and each beat touches every bank once.
//   - A byte-wide display port returns the RAM byte XOR the key, one cycle
//     after the address.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   req_valid/ready   processor request handshake (ready low while busy/reset)
//   req_write         1 = write, 0 = read
//   req_vector        1 = LANES-word vector access
//   req_addr          byte address (bits [1:0] ignored)
//   wdata / rdata     LANES*DATA_WIDTH data; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rvalid            one-cycle pulse when rdata carries a read result
//   button_in         asynchronous button, sets the pending bit on a rising edge
//   irq               pending AND enable
//   stream_addr       display byte address, sampled every cycle
//   stream_data       RAM byte XOR key (0 when out of range)
//   stream_valid      stream_data comes from an in-range address
module banked_iomemory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LANES      = 4,
  parameter int NUM_BANKS  = 2,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(32'h0003_0000),
  parameter logic [ADDR_WIDTH-1:0] KEY_ADDR    = ADDR_WIDTH'(32'h0003_0004)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic                          req_vector,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [LANES*DATA_WIDTH-1:0]   wdata,
  output logic [LANES*DATA_WIDTH-1:0]   rdata,
  output logic                          rvalid,
  input  logic                          button_in,
  output logic                          irq,
  input  logic [ADDR_WIDTH-1:0]         stream_addr,
  output logic [7:0]                    stream_data,
  output logic                          stream_valid
);

  localparam int WORD_W  = ADDR_WIDTH - 2;
  localparam int BEATS   = LANES / NUM_BANKS;
  localparam int ROWS    = DEPTH / NUM_BANKS;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam bit MULTI_BEAT = (BEATS > 1);

  localparam logic [WORD_W-1:0] DEPTH_W      = WORD_W'(DEPTH);
  localparam logic [WORD_W-1:0] LANES_W      = WORD_W'(LANES);
  localparam logic [WORD_W-1:0] NB_W         = WORD_W'(NUM_BANKS);
  localparam logic [WORD_W-1:0] STATUS_WORD  = STATUS_ADDR[ADDR_WIDTH-1:2];
  localparam logic [WORD_W-1:0] KEY_WORD     = KEY_ADDR[ADDR_WIDTH-1:2];
  // Vector blocks that would cover a register word are rejected as a whole.
  localparam logic [WORD_W-1:0] STATUS_VBASE = STATUS_WORD - (STATUS_WORD % LANES_W);
  localparam logic [WORD_W-1:0] KEY_VBASE    = KEY_WORD - (KEY_WORD % LANES_W);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t                r_state, w_state_next;
  logic [BEAT_W-1:0]     r_beat, w_beat_next;

  logic [DATA_WIDTH-1:0] r_mem [NUM_BANKS][ROWS];

  // Vector request captured at accept, replayed on the later beats.
  logic                        r_vwrite, r_vok;
  logic [ROW_W-1:0]            r_vrow;
  logic [LANES*DATA_WIDTH-1:0] r_wdata, r_acc;

  logic       r_pending, r_enable;
  logic [7:0] r_key;
  logic       r_btn_s1, r_btn_s2, r_btn_s3;

  // ---------------- request decode ----------------
  logic [WORD_W-1:0] w_word, w_vbase;
  logic              w_hit_status, w_hit_key, w_scalar_ram, w_vec_ok;
  logic [BANK_W-1:0] w_sbank;
  logic [ROW_W-1:0]  w_srow, w_vrow;
  logic              w_unused_addr_bits;

  assign w_word       = req_addr[ADDR_WIDTH-1:2];
  assign w_vbase      = w_word - (w_word % LANES_W);
  assign w_hit_status = (w_word == STATUS_WORD);
  assign w_hit_key    = (w_word == KEY_WORD);
  assign w_scalar_ram = !w_hit_status && !w_hit_key && (w_word < DEPTH_W);
  assign w_vec_ok     = (w_vbase < DEPTH_W) && (w_vbase != STATUS_VBASE) && (w_vbase != KEY_VBASE);
  assign w_sbank      = BANK_W'(w_word % NB_W);
  assign w_srow       = ROW_W'(w_word / NB_W);
  // The vector base is a multiple of NUM_BANKS, so lane b*NUM_BANKS+k always
  // lands in bank k at row base/NUM_BANKS + b.
  assign w_vrow       = ROW_W'(w_vbase / NB_W);
  assign w_unused_addr_bits = ^req_addr[1:0];

  // ---------------- beat control ----------------
  logic w_accept, w_busy, w_beat_active, w_last_beat;

  assign req_ready     = rst_n && (r_state == ST_IDLE);
  assign w_accept      = req_valid && req_ready;
  assign w_busy        = (r_state == ST_BUSY);
  assign w_beat_active = w_accept || (w_busy && rst_n);
  assign w_last_beat   = (r_beat == BEAT_W'(BEATS - 1));

  // Beat 0 runs straight from the request; later beats use the captured copy.
  logic                        w_cur_vec, w_cur_write, w_cur_vok;
  logic [ROW_W-1:0]            w_cur_vrow;
  logic [LANES*DATA_WIDTH-1:0] w_cur_wdata;

  assign w_cur_vec   = w_busy ? 1'b1     : req_vector;
  assign w_cur_write = w_busy ? r_vwrite : req_write;
  assign w_cur_vok   = w_busy ? r_vok    : w_vec_ok;
  assign w_cur_vrow  = w_busy ? r_vrow   : w_vrow;
  assign w_cur_wdata = w_busy ? r_wdata  : wdata;

  logic [NUM_BANKS-1:0]        w_bank_we;
  logic [ROW_W-1:0]            w_bank_row [NUM_BANKS];
  logic [DATA_WIDTH-1:0]       w_bank_wd  [NUM_BANKS];
  logic [LANES*DATA_WIDTH-1:0] w_vec_rd;
  logic [DATA_WIDTH-1:0]       w_scalar_rd;

  // Per-bank processor port: row, write enable and write data for this beat,
  // plus the vector read accumulator with this beat's lanes merged in.
  always_comb begin
    w_vec_rd = r_acc;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (w_cur_vec) begin
        w_bank_row[k] = w_cur_vrow + ROW_W'(r_beat);
        w_bank_we[k]  = w_beat_active && w_cur_write && w_cur_vok;
        w_bank_wd[k]  = w_cur_wdata[(int'(r_beat) * NUM_BANKS + k) * DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_bank_row[k] = w_srow;
        w_bank_we[k]  = w_beat_active && w_cur_write && w_scalar_ram && (w_sbank == BANK_W'(k));
        w_bank_wd[k]  = w_cur_wdata[DATA_WIDTH-1:0];
      end
      if (w_cur_vok) begin
        w_vec_rd[(int'(r_beat) * NUM_BANKS + k) * DATA_WIDTH +: DATA_WIDTH] = r_mem[k][w_bank_row[k]];
      end else begin
        w_vec_rd[(int'(r_beat) * NUM_BANKS + k) * DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Scalar read source: status, key, RAM word or zero for unmapped addresses.
  always_comb begin
    if (w_hit_status) begin
      w_scalar_rd = DATA_WIDTH'({r_enable, r_pending});
    end else if (w_hit_key) begin
      w_scalar_rd = DATA_WIDTH'(r_key);
    end else if (w_scalar_ram) begin
      w_scalar_rd = r_mem[w_sbank][w_srow];
    end else begin
      w_scalar_rd = '0;
    end
  end

  // FSM next state: only multi-beat vectors leave IDLE.
  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && req_vector && MULTI_BEAT) begin
          w_state_next = ST_BUSY;
          w_beat_next  = BEAT_W'(1);
        end else begin
          w_beat_next  = '0;
        end
      end
      ST_BUSY: begin
        if (w_last_beat) begin
          w_state_next = ST_IDLE;
          w_beat_next  = '0;
        end else begin
          w_beat_next  = r_beat + BEAT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_beat_next  = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_next;
      r_beat  <= w_beat_next;
    end
  end

  // RAM banks: contents survive reset, and a beat at a reset edge does not commit.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (w_bank_we[k]) begin
        r_mem[k][w_bank_row[k]] <= w_bank_wd[k];
      end
    end
  end

  // Read data path and vector request capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid   <= 1'b0;
      rdata    <= '0;
      r_acc    <= '0;
      r_vwrite <= 1'b0;
      r_vok    <= 1'b0;
      r_vrow   <= '0;
      r_wdata  <= '0;
    end else begin
      rvalid <= 1'b0;
      if (w_accept && req_vector) begin
        r_vwrite <= req_write;
        r_vok    <= w_vec_ok;
        r_vrow   <= w_vrow;
        r_wdata  <= wdata;
      end
      if (w_beat_active && !w_cur_write) begin
        if (w_cur_vec) begin
          r_acc <= w_vec_rd;
          if (w_last_beat) begin
            rdata  <= w_vec_rd;
            rvalid <= 1'b1;
          end
        end else begin
          rdata  <= (LANES * DATA_WIDTH)'(w_scalar_rd);
          rvalid <= 1'b1;
        end
      end
    end
  end

  // Status/key registers and the button synchroniser.
  logic w_scalar_acc, w_rise, w_pend_clr;
  assign w_scalar_acc = w_accept && !req_vector;
  assign w_rise       = r_btn_s2 && !r_btn_s3;
  assign w_pend_clr   = w_scalar_acc && w_hit_status && (!req_write || wdata[0]);

  // A clear and a new button edge in the same cycle leave pending set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_s1  <= 1'b0;
      r_btn_s2  <= 1'b0;
      r_btn_s3  <= 1'b0;
      r_pending <= 1'b0;
      r_enable  <= 1'b0;
      r_key     <= 8'h00;
    end else begin
      r_btn_s1 <= button_in;
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
      if (w_rise) begin
        r_pending <= 1'b1;
      end else if (w_pend_clr) begin
        r_pending <= 1'b0;
      end
      if (w_scalar_acc && req_write && w_hit_status) begin
        r_enable <= wdata[1];
      end
      if (w_scalar_acc && req_write && w_hit_key) begin
        r_key <= wdata[7:0];
      end
    end
  end

  assign irq = r_pending && r_enable;

  // ---------------- display stream port ----------------
  logic [WORD_W-1:0]     w_s_word;
  logic                  w_s_ok;
  logic [DATA_WIDTH-1:0] w_s_data;
  logic [7:0]            w_s_byte;

  assign w_s_word = stream_addr[ADDR_WIDTH-1:2];
  assign w_s_ok   = (w_s_word < DEPTH_W);
  assign w_s_data = r_mem[BANK_W'(w_s_word % NB_W)][ROW_W'(w_s_word / NB_W)];
  assign w_s_byte = 8'(w_s_data >> {stream_addr[1:0], 3'b000});

  // Stream output register: a same-edge processor write is not visible yet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stream_data  <= 8'h00;
      stream_valid <= 1'b0;
    end else if (w_s_ok) begin
      stream_data  <= w_s_byte ^ r_key;
      stream_valid <= 1'b1;
    end else begin
      stream_data  <= 8'h00;
      stream_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_banked_iomemory.sv
// Directed bench for banked_iomemory with the default parameters
// (32-bit words, LANES=4, NUM_BANKS=2, DEPTH=1024).
module tb_banked_iomemory;
  localparam int AW = 32;
  localparam int VW = 128;
  localparam logic [AW-1:0] STATUS = 32'h0003_0000;
  localparam logic [AW-1:0] KEY    = 32'h0003_0004;

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_ready, req_write, req_vector;
  logic [AW-1:0] req_addr, stream_addr;
  logic [VW-1:0] wdata, rdata;
  logic          rvalid, button_in, irq, stream_valid;
  logic [7:0]    stream_data;

  int checks = 0;
  int errors = 0;

  banked_iomemory dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_vector(req_vector), .req_addr(req_addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .button_in(button_in),
    .irq(irq), .stream_addr(stream_addr), .stream_data(stream_data),
    .stream_valid(stream_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted request (one edge); req_valid drops afterwards.
  task automatic issue(input logic wr, input logic vec, input logic [AW-1:0] addr, input logic [VW-1:0] data);
    req_valid  = 1'b1;
    req_write  = wr;
    req_vector = vec;
    req_addr   = addr;
    wdata      = data;
    tick();
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_vector = 1'b0;
  endtask

  logic [7:0] exp_s [4];

  initial begin
    exp_s = '{8'h1E, 8'h69, 8'h78, 8'h4B};
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_vector = 1'b0;
    req_addr = '0; wdata = '0; button_in = 1'b0; stream_addr = STATUS;

    // Reset state
    tick(); tick();
    check("rst_ready", req_ready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_irq", irq, 0);
    check("rst_svalid", stream_valid, 0);
    check("rst_sdata", stream_data, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", req_ready, 1);

    // Scalar write then back-to-back read
    issue(1'b1, 1'b0, 32'h10, 128'hA);
    check("sw_ready", req_ready, 1);
    check("sw_no_rvalid", rvalid, 0);
    issue(1'b0, 1'b0, 32'h10, 128'h0);
    check("sr_rvalid", rvalid, 1);
    check("sr_rdata", rdata, 128'hA);
    check("sr_ready", req_ready, 1);
    tick();
    check("sr_pulse", rvalid, 0);
    check("sr_hold", rdata, 128'hA);

    // Vector write / read
    issue(1'b1, 1'b1, 32'h404, {32'd4, 32'd3, 32'd2, 32'd1});
    check("vw_busy", req_ready, 0);
    check("vw_no_rvalid", rvalid, 0);
    tick();
    check("vw_ready", req_ready, 1);
    issue(1'b0, 1'b1, 32'h400, 128'h0);
    check("vr_busy", req_ready, 0);
    check("vr_early", rvalid, 0);
    tick();
    check("vr_rvalid", rvalid, 1);
    check("vr_rdata", rdata, {32'd4, 32'd3, 32'd2, 32'd1});
    check("vr_ready", req_ready, 1);
    issue(1'b0, 1'b0, 32'h408, 128'h0);
    check("lane2", rdata, 128'd3);
    issue(1'b0, 1'b0, 32'h40C, 128'h0);
    check("lane3", rdata, 128'd4);

    // Key register and stream port
    issue(1'b1, 1'b0, KEY, 128'hABCD_EF5A);
    issue(1'b0, 1'b0, KEY, 128'h0);
    check("key_rd", rdata, 128'h5A);
    issue(1'b1, 1'b0, 32'h10, 128'h1122_3344);
    for (int i = 0; i < 4; i++) begin
      stream_addr = 32'h10 + 32'(i);
      tick();
      check("stream_valid", stream_valid, 1);
      check("stream_byte", stream_data, exp_s[i]);
    end
    stream_addr = STATUS;
    tick();
    check("stream_oor_valid", stream_valid, 0);
    check("stream_oor_data", stream_data, 0);
    stream_addr = 32'h1000;
    tick();
    check("stream_depth_valid", stream_valid, 0);
    stream_addr = 32'h10;
    issue(1'b1, 1'b0, 32'h10, 128'h55);
    check("stream_old_data", stream_data, 8'h1E);
    tick();
    check("stream_new_data", stream_data, 8'h0F);

    // Button interrupt
    issue(1'b1, 1'b0, STATUS, 128'h2);
    check("irq_idle", irq, 0);
    button_in = 1'b1;
    tick();
    check("irq_e0", irq, 0);
    tick();
    check("irq_e1", irq, 0);
    tick();
    check("irq_e2", irq, 1);
    button_in = 1'b0;
    issue(1'b0, 1'b0, STATUS, 128'h0);
    check("status_rd1", rdata, 128'h3);
    check("irq_cleared", irq, 0);
    issue(1'b0, 1'b0, STATUS, 128'h0);
    check("status_rd2", rdata, 128'h2);
    button_in = 1'b1;
    tick(); tick(); tick();
    check("irq_again", irq, 1);
    button_in = 1'b0;
    issue(1'b1, 1'b0, STATUS, 128'h3);
    check("irq_w1c", irq, 0);
    issue(1'b0, 1'b0, STATUS, 128'h0);
    check("status_after_w1c", rdata, 128'h2);

    // Reset in the middle of a vector write
    issue(1'b1, 1'b1, 32'h800, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    tick();
    issue(1'b1, 1'b1, 32'h800, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    rst_n = 1'b0;
    #1;
    check("rstbusy_ready", req_ready, 0);
    tick();
    check("rstbusy_ready2", req_ready, 0);
    check("rstbusy_rvalid", rvalid, 0);
    check("rstbusy_irq", irq, 0);
    rst_n = 1'b1;
    #1;
    check("rstbusy_ready_after", req_ready, 1);
    issue(1'b0, 1'b0, STATUS, 128'h0);
    check("rst_status", rdata, 0);
    issue(1'b0, 1'b0, KEY, 128'h0);
    check("rst_key", rdata, 0);
    issue(1'b0, 1'b1, 32'h800, 128'h0);
    tick();
    check("partial_vec", rdata, {32'hA3, 32'hA2, 32'hB1, 32'hB0});

    // Out-of-range and vector-to-register accesses
    issue(1'b1, 1'b0, 32'h0, 128'h77);
    issue(1'b0, 1'b0, 32'h1000, 128'h0);
    check("oor_rvalid", rvalid, 1);
    check("oor_rdata", rdata, 0);
    issue(1'b1, 1'b0, 32'h1000, 128'hDEAD);
    issue(1'b0, 1'b0, 32'h0, 128'h0);
    check("oor_no_alias", rdata, 128'h77);
    issue(1'b0, 1'b1, STATUS, 128'h0);
    check("vstat_early", rvalid, 0);
    check("vstat_busy", req_ready, 0);
    tick();
    check("vstat_rvalid", rvalid, 1);
    check("vstat_rdata", rdata, 0);
    issue(1'b1, 1'b1, STATUS, {VW{1'b1}});
    tick();
    issue(1'b0, 1'b0, STATUS, 128'h0);
    check("vstat_w_status", rdata, 0);
    issue(1'b0, 1'b0, KEY, 128'h0);
    check("vstat_w_key", rdata, 0);
    issue(1'b0, 1'b0, 32'h0, 128'h0);
    check("vstat_w_ram", rdata, 128'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
